// File: rtl/demux4bits_stream_pkg.sv
// Shared defaults and constants for the 4-bit stream demultiplexer.
// The module parameters take their default values from these constants.
package demux4bits_pkg;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_CNT_W = 8;
    localparam int PTR_W     = $clog2(DEF_DEPTH);

    localparam logic SEL_A = 1'b1;
endpackage

// File: rtl/demux4bits_stream_if.sv
// Bundle of the producer stream, the two consumer streams and the per-port beat counters.
// Valid/ready rule, on every stream: a beat transfers on a rising clk edge where valid && ready.
// Once valid is high, the source holds data (and sel) stable until that transfer.
interface demux4bits_stream_if
    import demux4bits_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;

    logic             outA_valid;
    logic             outA_ready;
    logic [WIDTH-1:0] outA_data;

    logic             outB_valid;
    logic             outB_ready;
    logic [WIDTH-1:0] outB_data;

    logic [CNT_W-1:0] cntA;
    logic [CNT_W-1:0] cntB;

    modport slave (
        input  in_valid, in_data, in_sel, outA_ready, outB_ready,
        output in_ready, outA_valid, outA_data, outB_valid, outB_data, cntA, cntB
    );

    modport master (
        output in_valid, in_data, in_sel, outA_ready, outB_ready,
        input  in_ready, outA_valid, outA_data, outB_valid, outB_data, cntA, cntB
    );
endinterface

// File: rtl/nibble_fifo.sv
// Small synchronous FIFO with a registered head-hold value, so head_data
// keeps the last popped beat while the FIFO is empty (zero after reset).
module nibble_fifo
    import demux4bits_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    // A push into a full FIFO is dropped; the parent never issues one.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            hold_d   = mem_q[rd_ptr_q];
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    assign head_data = empty ? hold_q : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end
endmodule

// File: rtl/demux4bits_stream.sv
// Routes one nibble stream to port A or B by a per-beat select bit; each port
// is buffered by its own FIFO and has a wrapping count of accepted beats.
module demux4bits_stream
    import demux4bits_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux4bits_stream_if.slave   bus
);
    logic             full_a, empty_a, full_b, empty_b;
    logic             in_ready, accept;
    logic             push_a, push_b, pop_a, pop_b;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

    // Ready looks only at the selected FIFO's fullness, never at consumer ready.
    assign in_ready = ((bus.in_sel == SEL_A) ? !full_a : !full_b) && rst_n;
    assign accept   = bus.in_valid && in_ready;
    assign push_a   = accept && (bus.in_sel == SEL_A);
    assign push_b   = accept && (bus.in_sel != SEL_A);
    assign pop_a    = !empty_a && bus.outA_ready;
    assign pop_b    = !empty_b && bus.outB_ready;

    nibble_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data (bus.in_data),
        .pop       (pop_a),
        .head_data (bus.outA_data),
        .full      (full_a),
        .empty     (empty_a)
    );

    nibble_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data (bus.in_data),
        .pop       (pop_b),
        .head_data (bus.outB_data),
        .full      (full_b),
        .empty     (empty_b)
    );

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (push_a) cnt_a_d = cnt_a_q + 1'b1;
        if (push_b) cnt_b_d = cnt_b_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.outA_valid = !empty_a;
    assign bus.outB_valid = !empty_b;
    assign bus.cntA       = cnt_a_q;
    assign bus.cntB       = cnt_b_q;
endmodule

// File: tb/tb_demux4bits_stream.sv
// Self-checking bench for demux4bits_stream: per-port expected queues filled on
// accepted input beats and drained on output handshakes, plus per-scenario checks.
module tb_demux4bits_stream;
    import demux4bits_pkg::*;

    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];
    logic [7:0]   mcnt_a = '0;
    logic [7:0]   mcnt_b = '0;

    demux4bits_stream_if #(.WIDTH(W), .CNT_W(8)) bus ();

    demux4bits_stream #(.WIDTH(W), .DEPTH(2), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: handshakes sampled mid-cycle, ahead of the edge where they transfer.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                if (bus.in_sel) begin
                    exp_a_q.push_back(bus.in_data);
                    mcnt_a = mcnt_a + 8'd1;
                end else begin
                    exp_b_q.push_back(bus.in_data);
                    mcnt_b = mcnt_b + 8'd1;
                end
            end
            if (bus.outA_valid && bus.outA_ready) begin
                n_cmp++;
                if (exp_a_q.size() == 0) begin
                    n_err++;
                    $display("FAIL port_a_unexpected got=%h exp=<none>", bus.outA_data);
                end else begin
                    e = exp_a_q.pop_front();
                    if (bus.outA_data !== e) begin
                        n_err++;
                        $display("FAIL port_a_data got=%h exp=%h", bus.outA_data, e);
                    end
                end
            end
            if (bus.outB_valid && bus.outB_ready) begin
                n_cmp++;
                if (exp_b_q.size() == 0) begin
                    n_err++;
                    $display("FAIL port_b_unexpected got=%h exp=<none>", bus.outB_data);
                end else begin
                    e = exp_b_q.pop_front();
                    if (bus.outB_data !== e) begin
                        n_err++;
                        $display("FAIL port_b_data got=%h exp=%h", bus.outB_data, e);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [W-1:0] d, input logic s, output int waited);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sel   = s;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout got=in_ready_low exp=accept data=%h sel=%0b", d, s);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        bus.outA_ready = 1'b1;
        bus.outB_ready = 1'b1;
        n = 0;
        while ((bus.outA_valid || bus.outB_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0 || bus.outA_valid || bus.outB_valid) begin
            n_err++;
            $display("FAIL drain_empty got=qa%0d/qb%0d/va%0b/vb%0b exp=0/0/0/0",
                     exp_a_q.size(), exp_b_q.size(), bus.outA_valid, bus.outB_valid);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        exp_a_q.delete();
        exp_b_q.delete();
        mcnt_a = '0;
        mcnt_b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int w;
        #2;
        n_cmp += 4;
        if (bus.outA_valid !== 1'b0 || bus.outB_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_valid got=%b%b exp=00", bus.outA_valid, bus.outB_valid);
        end
        if (bus.outA_data !== 4'h0 || bus.outB_data !== 4'h0) begin
            n_err++;
            $display("FAIL rst_data got=%h/%h exp=0/0", bus.outA_data, bus.outB_data);
        end
        if (bus.cntA !== 8'd0 || bus.cntB !== 8'd0) begin
            n_err++;
            $display("FAIL rst_cnt got=%0d/%0d exp=0/0", bus.cntA, bus.cntB);
        end
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_rst_ready got=%b exp=1", bus.in_ready);
        end
        // Two beats parked in A, a third stalled, then an asynchronous reset mid-cycle.
        bus.outA_ready = 1'b0;
        send_beat(4'h6, 1'b1, w);
        send_beat(4'hE, 1'b1, w);
        n_cmp++;
        if (bus.cntA !== 8'd2) begin
            n_err++;
            $display("FAIL pre_rst_cnt_a got=%0d exp=2", bus.cntA);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h1;
        bus.in_sel   = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_a_q.delete();
        exp_b_q.delete();
        mcnt_a = '0;
        mcnt_b = '0;
        #1;
        n_cmp += 3;
        if (bus.outA_valid !== 1'b0 || bus.outA_data !== 4'h0) begin
            n_err++;
            $display("FAIL midrst_out_a got=v%b/d%h exp=v0/d0", bus.outA_valid, bus.outA_data);
        end
        if (bus.cntA !== 8'd0) begin
            n_err++;
            $display("FAIL midrst_cnt_a got=%0d exp=0", bus.cntA);
        end
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_in_ready got=%b exp=0", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.outA_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rel_rst got=rdy%b/va%b exp=rdy1/va0", bus.in_ready, bus.outA_valid);
        end
    endtask

    task automatic test_routing();
        int w;
        bus.outA_ready = 1'b1;
        bus.outB_ready = 1'b1;
        send_beat(4'h3, 1'b1, w);
        n_cmp += 2;
        if (w !== 0) begin
            n_err++;
            $display("FAIL route_a_wait got=%0d exp=0", w);
        end
        if (bus.outA_valid !== 1'b1 || bus.outA_data !== 4'h3 || bus.outB_valid !== 1'b0) begin
            n_err++;
            $display("FAIL route_a got=va%b/d%h/vb%b exp=va1/d3/vb0",
                     bus.outA_valid, bus.outA_data, bus.outB_valid);
        end
        send_beat(4'hC, 1'b0, w);
        n_cmp++;
        if (bus.outB_valid !== 1'b1 || bus.outB_data !== 4'hC) begin
            n_err++;
            $display("FAIL route_b got=vb%b/d%h exp=vb1/dc", bus.outB_valid, bus.outB_data);
        end
        @(posedge clk);
        #1;
        n_cmp += 2;
        if (bus.cntA !== 8'd1 || bus.cntB !== 8'd1) begin
            n_err++;
            $display("FAIL route_cnt got=%0d/%0d exp=1/1", bus.cntA, bus.cntB);
        end
        if (bus.outA_valid !== 1'b0 || bus.outA_data !== 4'h3) begin
            n_err++;
            $display("FAIL route_hold_a got=va%b/d%h exp=va0/d3", bus.outA_valid, bus.outA_data);
        end
    endtask

    task automatic test_backpressure();
        int w;
        int stalled;
        bus.outA_ready = 1'b0;
        bus.outB_ready = 1'b1;
        send_beat(4'h8, 1'b1, w);
        send_beat(4'h9, 1'b1, w);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hA;
        bus.in_sel   = 1'b1;
        stalled = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.in_ready === 1'b0) stalled++;
        end
        n_cmp++;
        if (stalled != 3) begin
            n_err++;
            $display("FAIL bp_stall got=%0d exp=3", stalled);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        send_beat(4'h5, 1'b0, w);
        n_cmp += 2;
        if (w !== 0 || bus.outB_valid !== 1'b1 || bus.outB_data !== 4'h5) begin
            n_err++;
            $display("FAIL bp_b_pass got=w%0d/vb%b/d%h exp=w0/vb1/d5", w, bus.outB_valid, bus.outB_data);
        end
        if (bus.outA_valid !== 1'b1 || bus.outA_data !== 4'h8) begin
            n_err++;
            $display("FAIL bp_a_held got=va%b/d%h exp=va1/d8", bus.outA_valid, bus.outA_data);
        end
        drain();
    endtask

    task automatic test_full_pop();
        int w;
        bus.outA_ready = 1'b0;
        send_beat(4'h1, 1'b1, w);
        send_beat(4'h2, 1'b1, w);
        bus.outA_ready = 1'b1;
        send_beat(4'h7, 1'b1, w);
        n_cmp++;
        if (w !== 1) begin
            n_err++;
            $display("FAIL full_pop_wait got=%0d exp=1", w);
        end
        drain();
        n_cmp++;
        if (bus.outA_valid !== 1'b0 || bus.outA_data !== 4'h7) begin
            n_err++;
            $display("FAIL full_pop_hold got=va%b/d%h exp=va0/d7", bus.outA_valid, bus.outA_data);
        end
    endtask

    task automatic test_counter_wrap();
        int w;
        do_reset();
        bus.outB_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send_beat(W'($urandom_range(0, 15)), 1'b0, w);
            if (i == 254) begin
                n_cmp++;
                if (bus.cntB !== 8'd255) begin
                    n_err++;
                    $display("FAIL wrap_255 got=%0d exp=255", bus.cntB);
                end
            end
        end
        n_cmp++;
        if (bus.cntB !== 8'd0 || bus.cntA !== 8'd0) begin
            n_err++;
            $display("FAIL wrap_zero got=%0d/%0d exp=0/0", bus.cntA, bus.cntB);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int w;
        int total_w;
        int start;
        bus.outA_ready = 1'b1;
        bus.outB_ready = 1'b1;
        total_w = 0;
        start = cyc;
        for (int i = 0; i < 16; i++) begin
            send_beat(W'($urandom_range(0, 15)), (i % 2) == 0, w);
            total_w += w;
        end
        n_cmp++;
        if ((cyc - start) != 16 || total_w != 0) begin
            n_err++;
            $display("FAIL b2b_rate got=%0d_cycles/%0d_stalls exp=16/0", cyc - start, total_w);
        end
        drain();
        n_cmp++;
        if (bus.cntA !== mcnt_a || bus.cntB !== mcnt_b) begin
            n_err++;
            $display("FAIL b2b_cnt got=%0d/%0d exp=%0d/%0d", bus.cntA, bus.cntB, mcnt_a, mcnt_b);
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_sel     = 1'b1;
        bus.outA_ready = 1'b0;
        bus.outB_ready = 1'b0;
        test_reset();
        test_routing();
        test_backpressure();
        test_full_pop();
        test_counter_wrap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
